// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the LC-3 PC / branch-enable slice.
// This file holds the PCMUX source encodings, the branch tracker state
// encodings, the default reset vector, and the BEN evaluation helper.
package pc_branch_unit_pkg;

  // PCMUX source select encodings (selPC).
  localparam logic [1:0] PCMUX_INC  = 2'b00;  // PC + 1
  localparam logic [1:0] PCMUX_BUS  = 2'b01;  // shared data bus
  localparam logic [1:0] PCMUX_EAB  = 2'b10;  // effective-address adder
  localparam logic [1:0] PCMUX_HOLD = 2'b11;  // keep current PC

  // LC-3 user program origin.
  localparam logic [15:0] LC3_RESET_VECTOR = 16'h3000;

  // Branch tracker states.
  // BR_IDLE: no branch has been evaluated since the last resolution.
  // BR_PEND: BEN has been latched and the next PC load resolves the branch.
  typedef enum logic {
    BR_IDLE = 1'b0,
    BR_PEND = 1'b1
  } br_state_t;

  // Branch condition: any IR[11:9] mask bit that matches a set flag.
  function automatic logic ben_eval(input logic [2:0] nzp_mask,
                                    input logic n, input logic z,
                                    input logic p);
    ben_eval = (nzp_mask[2] & n) | (nzp_mask[1] & z) | (nzp_mask[0] & p);
  endfunction

endpackage

// File: rtl/br_perf_counter.sv
// Saturating 16-bit event counter with synchronous clear.
// The count sticks at 16'hFFFF instead of wrapping, so a
// long-running count never reads as a small number.
module br_perf_counter
  import pc_branch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  // Count qualifying events; clear on reset, hold at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'h0000;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// LC-3 program counter and branch-enable (BEN) unit.
//
// PC loads from PC+1, the bus or the address adder when ldPC is high.
// BEN is evaluated from IR[11:9] and the N/Z/P flags when ldBEN is high.
// A small tracker follows each evaluated branch until the next PC load
// and pulses brTaken for one cycle when that load was a taken branch
// (old BEN set and PC sourced from the address adder).
//
// Handshake note: there is no valid/ready flow here. ldPC and ldBEN are
// single-cycle strobes from the multicycle controller; every strobe is
// accepted at the next rising edge, and the two are independent when
// asserted together (resolution then uses the BEN value from before
// that edge).
//
// Optional feature: define BRANCH_PERF_EN to add the brCount and
// brTakenCount saturating performance counters and their output ports.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = LC3_RESET_VECTOR
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ldPC,
  input  logic [1:0]  selPC,
  input  logic        ldBEN,
  input  logic [2:0]  nzpIR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic [15:0] Buss,
  input  logic [15:0] eabOut,
  output logic [15:0] PC,
  output logic        BEN,
  output logic        brTaken,
  output logic        br_state
`ifdef BRANCH_PERF_EN
  ,
  output logic [15:0] brCount,
  output logic [15:0] brTakenCount
`endif
);

  br_state_t   state;
  logic [15:0] pc_next;
  logic        ben_next;
  logic        resolve;
  logic        take;

  // Tracker state is visible for observation.
  assign br_state = state;

  // PC source selection; HOLD feeds the current PC back.
  always_comb begin
    pc_next = PC;
    case (selPC)
      PCMUX_INC:  pc_next = PC + 16'h0001;
      PCMUX_BUS:  pc_next = Buss;
      PCMUX_EAB:  pc_next = eabOut;
      PCMUX_HOLD: pc_next = PC;
      default:    pc_next = PC;
    endcase
  end

  // Branch condition from the flags as presented this cycle.
  always_comb begin
    ben_next = ben_eval(nzpIR, N, Z, P);
  end

  // A pending branch resolves on the next PC load; taken only when the
  // old BEN is set and the new PC comes from the address adder.
  always_comb begin
    resolve = (state == BR_PEND) && ldPC;
    take    = resolve && BEN && (selPC == PCMUX_EAB);
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC <= RESET_VECTOR;
    end else if (ldPC) begin
      PC <= pc_next;
    end
  end

  // Branch-enable register; holds between evaluations.
  always_ff @(posedge clk) begin
    if (rst) begin
      BEN <= 1'b0;
    end else if (ldBEN) begin
      BEN <= ben_next;
    end
  end

  // Branch tracker with registered one-cycle taken pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BR_IDLE;
      brTaken <= 1'b0;
    end else begin
      brTaken <= take;
      case (state)
        BR_IDLE: begin
          if (ldBEN) state <= BR_PEND;
        end
        BR_PEND: begin
          // A fresh evaluation in the resolving cycle starts a new branch.
          if (ldPC) state <= ldBEN ? BR_PEND : BR_IDLE;
        end
        default: state <= BR_IDLE;
      endcase
    end
  end

`ifdef BRANCH_PERF_EN
  // Resolutions, taken or not.
  br_perf_counter u_br_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (resolve),
    .count (brCount)
  );

  // Taken branches; counted on the same edge that raises brTaken.
  br_perf_counter u_br_taken_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (take),
    .count (brTakenCount)
  );
`endif

endmodule
